// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a single-clock FIFO built
// around an external RAM with a one-cycle registered read port.
module fifo_ctrl #(
  parameter int RAM_DEPTH       = 32,
  parameter int RAM_ADDR_WIDTH  = 5,
  parameter int ALMOST_FULL_TH  = 28,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      flush,
  input  logic                      wr_req,
  input  logic                      rd_req,
  output logic                      ram_wr_en,
  output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                      ram_rd_en,
  output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [RAM_ADDR_WIDTH:0]   data_count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = RAM_ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);
  localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_acc;
  logic          rd_acc;
  logic          rd_vld_p1;
  logic          ovf_p1;
  logic          unf_p1;

  // Flags and acceptance decoded from the registered pointers only.
  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    data_count   = wr_ptr - rd_ptr;
    almost_full  = (data_count >= AF_TH);
    almost_empty = (data_count <= AE_TH);
    // Reset and flush both keep the RAM untouched in their cycle.
    wr_acc       = wr_req && !full  && !flush && !sys_rst;
    rd_acc       = rd_req && !empty && !flush && !sys_rst;
    ram_wr_en    = wr_acc;
    ram_rd_en    = rd_acc;
    ram_wr_addr  = wr_ptr[PW-2:0];
    ram_rd_addr  = rd_ptr[PW-2:0];
  end

  // ---- stage p0 -> p1: pointer update, read-valid and error pulses ----
  // Reset beats flush, flush beats requests; a full FIFO still accepts the read.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_vld_p1 <= 1'b0;
      ovf_p1    <= 1'b0;
      unf_p1    <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_vld_p1 <= 1'b0;
      ovf_p1    <= 1'b0;
      unf_p1    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      rd_vld_p1 <= rd_acc;
      ovf_p1    <= wr_req && full;
      unf_p1    <= rd_req && empty;
    end
  end

  assign rd_valid  = rd_vld_p1;
  assign overflow  = ovf_p1;
  assign underflow = unf_p1;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed and randomized bench for fifo_ctrl against a
// word-count model of the FIFO.
module tb_fifo_ctrl;

  localparam int D  = 32;
  localparam int AW = 5;

  logic          sys_clk = 1'b0;
  logic          sys_rst, flush, wr_req, rd_req;
  logic          ram_wr_en, ram_rd_en, rd_valid, full, empty;
  logic          almost_full, almost_empty, overflow, underflow;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [AW:0]   data_count;

  fifo_ctrl #(.RAM_DEPTH(D), .RAM_ADDR_WIDTH(AW),
              .ALMOST_FULL_TH(28), .ALMOST_EMPTY_TH(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .flush(flush),
    .wr_req(wr_req), .rd_req(rd_req),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr),
    .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .data_count(data_count), .overflow(overflow), .underflow(underflow)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: stored word count, next write/read RAM address, pending pulses.
  int m_cnt = 0, m_wa = 0, m_ra = 0;
  bit m_rv = 0, m_ov = 0, m_un = 0;

  always @(negedge sys_clk) begin
    bit e_full, e_empty, w_ok, r_ok;
    #2;
    if (chk_en) begin
      e_full  = (m_cnt == D);
      e_empty = (m_cnt == 0);
      w_ok    = wr_req && !e_full  && !flush && !sys_rst;
      r_ok    = rd_req && !e_empty && !flush && !sys_rst;
      chk("full", 32'(full), 32'(e_full));
      chk("empty", 32'(empty), 32'(e_empty));
      chk("data_count", 32'(data_count), 32'(m_cnt));
      chk("almost_full", 32'(almost_full), 32'(m_cnt >= 28));
      chk("almost_empty", 32'(almost_empty), 32'(m_cnt <= 4));
      chk("ram_wr_en", 32'(ram_wr_en), 32'(w_ok));
      chk("ram_rd_en", 32'(ram_rd_en), 32'(r_ok));
      chk("ram_wr_addr", 32'(ram_wr_addr), 32'(m_wa));
      chk("ram_rd_addr", 32'(ram_rd_addr), 32'(m_ra));
      chk("rd_valid", 32'(rd_valid), 32'(m_rv));
      chk("overflow", 32'(overflow), 32'(m_ov));
      chk("underflow", 32'(underflow), 32'(m_un));
      if (sys_rst || flush) begin
        m_cnt = 0; m_wa = 0; m_ra = 0; m_rv = 0; m_ov = 0; m_un = 0;
      end else begin
        m_cnt = m_cnt + int'(w_ok) - int'(r_ok);
        m_wa  = (m_wa + int'(w_ok)) % D;
        m_ra  = (m_ra + int'(r_ok)) % D;
        m_rv  = r_ok;
        m_ov  = wr_req && e_full;
        m_un  = rd_req && e_empty;
      end
    end
  end

  task automatic cyc(input bit w, input bit r, input bit f, input bit rs);
    @(negedge sys_clk);
    wr_req = w; rd_req = r; flush = f; sys_rst = rs;
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
  endtask

  initial begin
    sys_rst = 1'b1; flush = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    @(posedge sys_clk);
    chk_en = 1'b1;
    @(posedge sys_clk);

    // reset state
    do_reset();
    #3;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_count", 32'(data_count), 32'd0);
    chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
    chk("rst_rd_en", 32'(ram_rd_en), 32'd0);

    // 32 back-to-back writes
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 0, 0);
      #3;
      chk("fill_addr", 32'(ram_wr_addr), 32'(i));
      chk("fill_afull", 32'(almost_full), 32'(i >= 28));
    end
    cyc(0, 0, 0, 0);
    #3;
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(data_count), 32'd32);

    // write into a full FIFO
    cyc(1, 0, 0, 0);
    #3;
    chk("ovf_wr_en", 32'(ram_wr_en), 32'd0);
    cyc(0, 0, 0, 0);
    #3;
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_waddr", 32'(ram_wr_addr), 32'd0);
    cyc(0, 0, 0, 0);
    #3;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // write 3, read 3
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      #3;
      chk("rd_addr", 32'(ram_rd_addr), 32'(i));
      chk("rd_valid_seq", 32'(rd_valid), 32'(i > 0));
    end
    cyc(0, 0, 0, 0);
    #3;
    chk("rd_valid_last", 32'(rd_valid), 32'd1);
    chk("rd_empty", 32'(empty), 32'd1);
    cyc(0, 0, 0, 0);
    #3;
    chk("rd_valid_off", 32'(rd_valid), 32'd0);

    // count 31, simultaneous read/write across the wrap
    do_reset();
    for (int i = 0; i < 31; i++) cyc(1, 0, 0, 0);
    for (int k = 0; k < 40; k++) begin
      cyc(1, 1, 0, 0);
      #3;
      chk("wrap_count", 32'(data_count), 32'd31);
      chk("wrap_waddr", 32'(ram_wr_addr), 32'((31 + k) % 32));
      chk("wrap_raddr", 32'(ram_rd_addr), 32'(k % 32));
      chk("wrap_flags", 32'({overflow, underflow, full, empty}), 32'd0);
    end

    // empty FIFO, simultaneous request
    do_reset();
    cyc(1, 1, 0, 0);
    #3;
    chk("emp_wr_en", 32'(ram_wr_en), 32'd1);
    chk("emp_rd_en", 32'(ram_rd_en), 32'd0);
    cyc(0, 0, 0, 0);
    #3;
    chk("emp_unf", 32'(underflow), 32'd1);
    chk("emp_count", 32'(data_count), 32'd1);
    cyc(0, 0, 0, 0);
    #3;
    chk("emp_unf_clr", 32'(underflow), 32'd0);

    // flush, then reset, at count 10 with both requests high
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0);
      cyc(1, 1, rep == 0, rep == 1);
      #3;
      chk("clr_en", 32'({ram_wr_en, ram_rd_en}), 32'd0);
      cyc(0, 0, 0, 0);
      #3;
      chk("clr_count", 32'(data_count), 32'd0);
      chk("clr_empty", 32'(empty), 32'd1);
      chk("clr_rv", 32'(rd_valid), 32'd0);
    end

    // read in flight, then reset
    do_reset();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1);
    #3;
    chk("inflight_rv", 32'(rd_valid), 32'd1);
    cyc(0, 0, 0, 0);
    #3;
    chk("inflight_clr", 32'(rd_valid), 32'd0);

    // randomized phases with varying write/read bias
    for (int p = 0; p < 6; p++) begin
      int wp, rp;
      wp = (p % 3 == 0) ? 80 : (p % 3 == 1) ? 20 : 50;
      rp = 100 - wp;
      for (int n = 0; n < 500; n++)
        cyc($urandom_range(99) < wp, $urandom_range(99) < rp,
            $urandom_range(199) == 0, $urandom_range(299) == 0);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    #4;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter RAM_DEPTH, default 32, meaning number of RAM words managed; must equal 2**RAM_ADDR_WIDTH.
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 5, meaning RAM address width.
REQ-003 SHALL have parameter ALMOST_FULL_TH, default 28, meaning almost_full asserts when data_count >= this value.
REQ-004 SHALL have parameter ALMOST_EMPTY_TH, default 4, meaning almost_empty asserts when data_count <= this value.
REQ-005 SHALL have port sys_clk, input, 1 bit: single clock, all logic rising-edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port flush, input, 1 bit: synchronous clear of FIFO contents.
REQ-008 SHALL have port wr_req, input, 1 bit: requester write request.
REQ-009 SHALL have port rd_req, input, 1 bit: requester read request.
REQ-010 SHALL have port ram_wr_en, output, 1 bit: RAM write enable (drives RAM wr_port_ena and wr_en).
REQ-011 SHALL have port ram_wr_addr, output, RAM_ADDR_WIDTH bits: RAM write address.
REQ-012 SHALL have port ram_rd_en, output, 1 bit: RAM read port enable.
REQ-013 SHALL have port ram_rd_addr, output, RAM_ADDR_WIDTH bits: RAM read address.
REQ-014 SHALL have port rd_valid, output, 1 bit: RAM rd_data holds the accepted read word this cycle.
REQ-015 SHALL have port full, output, 1 bit: FIFO full.
REQ-016 SHALL have port empty, output, 1 bit: FIFO empty.
REQ-017 SHALL have port almost_full, output, 1 bit: see REQ-003.
REQ-018 SHALL have port almost_empty, output, 1 bit: see REQ-004.
REQ-019 SHALL have port data_count, output, RAM_ADDR_WIDTH+1 bits: words stored, 0..RAM_DEPTH.
REQ-020 SHALL have port overflow, output, 1 bit: one-cycle pulse, write rejected.
REQ-021 SHALL have port underflow, output, 1 bit: one-cycle pulse, read rejected.

Function
REQ-022 SHALL keep wr_ptr and rd_ptr registers of RAM_ADDR_WIDTH+1 bits; MSB is the wrap bit.
REQ-023 SHALL accept a write when wr_req=1, full=0, flush=0; ram_wr_en SHALL equal this condition combinationally, ram_wr_addr SHALL equal wr_ptr[RAM_ADDR_WIDTH-1:0].
REQ-024 SHALL accept a read when rd_req=1, empty=0, flush=0; ram_rd_en SHALL equal this condition combinationally, ram_rd_addr SHALL equal rd_ptr[RAM_ADDR_WIDTH-1:0].
REQ-025 SHALL increment wr_ptr (rd_ptr) by 1 modulo 2**(RAM_ADDR_WIDTH+1) on each accepted write (read).
REQ-026 SHALL derive empty = (wr_ptr == rd_ptr), and full = (MSBs differ, low RAM_ADDR_WIDTH bits equal), from registered pointers only.
REQ-027 SHALL derive data_count = wr_ptr - rd_ptr (modulo 2**(RAM_ADDR_WIDTH+1)).
REQ-028 SHALL register rd_valid = accepted read of the previous cycle (1-cycle RAM read latency); no other data latency exists.
REQ-029 SHALL, on simultaneous accepted write and read, advance both pointers; data_count unchanged.
REQ-030 SHALL, when full and wr_req=rd_req=1, accept the read only; overflow pulses.
REQ-031 SHALL, when empty and wr_req=rd_req=1, accept the write only (no bypass); underflow pulses.
REQ-032 SHALL register overflow = wr_req & full & ~flush, underflow = rd_req & empty & ~flush, each visible one cycle after the request.
REQ-033 SHALL, on flush=1, zero both pointers at the next edge, suppress ram_wr_en/ram_rd_en that cycle, clear rd_valid next cycle; flush has priority over wr_req/rd_req.
REQ-034 SHALL not alter RAM contents on flush or reset.

Reset
REQ-035 SHALL, when sys_rst=1 at a rising edge, set wr_ptr=rd_ptr=0, rd_valid=0, overflow=0, underflow=0; sys_rst has priority over flush and requests.
REQ-036 SHALL, after reset, present empty=1, full=0, almost_empty=1, almost_full=0, data_count=0, ram_wr_en=0, ram_rd_en=0.
REQ-037 SHALL, on reset mid-operation, discard an in-flight read (rd_valid=0 next cycle).

Verification
REQ-038 Reset then 32 back-to-back writes -> ram_wr_addr 0..31, full=1 after 32nd edge, data_count=32, almost_full from count 28.
REQ-039 Full FIFO, wr_req=1 one cycle -> ram_wr_en=0, overflow=1 for exactly one cycle, wr_ptr unchanged.
REQ-040 Write 3 words, read 3 back-to-back -> ram_rd_addr 0,1,2; rd_valid high cycles 2-4 after first rd_req; empty=1 after third read.
REQ-041 Count=31, wr_req=rd_req=1 for 40 cycles -> count stays 31, addresses wrap 31->0, wrap bits toggle, no flags pulse.
REQ-042 Empty FIFO, wr_req=rd_req=1 -> write accepted, read rejected, underflow=1 one cycle, count=1.
REQ-043 Count=10, flush=1 with wr_req=rd_req=1 -> no RAM enables, count=0, empty=1 next cycle; repeat with sys_rst=1 -> same result.
